// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and helpers for the register slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  localparam int WORD_OFF_32 = 2;
  localparam int WORD_OFF_64 = 3;

  function automatic int word_off_bits(input int dw);
    return (dw == 64) ? WORD_OFF_64 : WORD_OFF_32;
  endfunction

  // Sized for the widest legal bus; narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_slv_if.sv
// AXI4-Lite signal bundle between an interconnect master and the register slave.
interface axil_reg_slv_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding register; accepts when empty, drains on pop.
module axil_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_pop
);
  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  assign in_ready  = !full_reg;
  assign out_valid = full_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (out_pop) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end
endmodule

// File: rtl/axil_reg_slv.sv
// AXI4-Lite slave exposing NUM_REGS memory-mapped registers with byte strobes,
// read-only status slots and SLVERR on out-of-range or read-only writes.
module axil_reg_slv
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  axil_reg_slv_if.slave                  bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = word_off_bits(DATA_WIDTH);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WORD_W = ADDR_WIDTH - OFF;
  localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_chk_dw
    $error("axil_reg_slv: DATA_WIDTH must be 32 or 64");
  end
  if (BASE_ADDR[OFF-1:0] != '0) begin : g_chk_base
    $error("axil_reg_slv: BASE_ADDR must be word aligned");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_chk_num
    $error("axil_reg_slv: NUM_REGS must be 1..256");
  end

  logic                  aw_full, w_full, wr_commit;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid_reg;
  axil_resp_e            bresp_reg;
  logic                  rvalid_reg;
  axil_resp_e            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  ar_ready;

  axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (bus.awvalid),
    .in_ready  (bus.awready),
    .in_data   (bus.awaddr),
    .out_valid (aw_full),
    .out_data  (aw_addr),
    .out_pop   (wr_commit)
  );

  axil_hold_reg #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (bus.wvalid),
    .in_ready  (bus.wready),
    .in_data   ({bus.wdata, bus.wstrb}),
    .out_valid (w_full),
    .out_data  ({w_data, w_strb}),
    .out_pop   (wr_commit)
  );

  // Decode at ADDR_WIDTH+1 bits so an address below BASE_ADDR shows up as a borrow.
  logic [ADDR_WIDTH:0] wr_off, rd_off;
  logic                wr_hit, rd_hit, wr_ok;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                unused_low_bits;

  assign wr_off = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
  assign rd_off = {1'b0, bus.araddr} - {1'b0, BASE_ADDR};
  assign wr_hit = !wr_off[ADDR_WIDTH] && (wr_off[ADDR_WIDTH-1:OFF] < NUM_REGS_W);
  assign rd_hit = !rd_off[ADDR_WIDTH] && (rd_off[ADDR_WIDTH-1:OFF] < NUM_REGS_W);
  assign wr_idx = wr_off[OFF +: IDX_W];
  assign rd_idx = rd_off[OFF +: IDX_W];
  assign wr_ok  = wr_hit && !RO_MASK[wr_idx];
  assign unused_low_bits = ^{wr_off[OFF-1:0], rd_off[OFF-1:0]};

  assign wr_commit = aw_full && w_full && (!bvalid_reg || bus.bready);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_src;

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign rd_src[gi]                          = hw_status[gi*DATA_WIDTH +: DATA_WIDTH];
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH]  = '0;
      assign reg_wr_pulse[gi]                    = 1'b0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  pulse_reg;
      logic                  wr_sel;
      logic                  unused_hw;

      assign wr_sel    = wr_commit && wr_ok && (wr_idx == IDX_W'(gi));
      assign unused_hw = ^hw_status[gi*DATA_WIDTH +: DATA_WIDTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_reg     <= RESET_VAL;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= wr_sel;
          if (wr_sel) begin
            q_reg <= DATA_WIDTH'(strb_merge(64'(q_reg), 64'(w_data), 8'(w_strb)));
          end
        end
      end

      assign rd_src[gi]                         = q_reg;
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
      assign reg_wr_pulse[gi]                   = pulse_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= OKAY;
    end else if (wr_commit) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= wr_ok ? OKAY : SLVERR;
    end else if (bus.bready) begin
      bvalid_reg <= 1'b0;
    end
  end

  // Registered read; a same-edge write is not yet visible in rd_src.
  assign ar_ready = !rvalid_reg || bus.rready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= OKAY;
    end else if (bus.arvalid && ar_ready) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_hit ? rd_src[rd_idx] : '0;
      rresp_reg  <= rd_hit ? OKAY : SLVERR;
    end else if (bus.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = ar_ready;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.rresp   = rresp_reg;
endmodule

// File: tb/tb_axil_reg_slv.sv
// Directed self-checking bench for axil_reg_slv (32-bit, 16 regs, reg 15 read-only).
module tb_axil_reg_slv;
  import axil_pkg::*;

  localparam logic [31:0] RV = 32'hA5A5_0000;
  localparam logic [31:0] HW15 = 32'h1234_5678;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [511:0] hw_status;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_pulse;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q [16];

  axil_reg_slv_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_slv #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0),
    .RO_MASK    (16'h8000),
    .RESET_VAL  (RV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .hw_status    (hw_status),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  assign hw_status = {HW15, {15{32'hFFFF_FFFF}}};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] exp_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_q[i];
    return v;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wr_bvalid_seen", 512'(bus.bvalid), 512'(1'b1));
    resp = bus.bresp;
    pulse = reg_wr_pulse;
    tick();
    bus.bready = 1'b0;
    $display("write addr=%h data=%h strb=%h resp=%0d pulse=%h", a, d, s, resp, pulse);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rd_rvalid_seen", 512'(bus.rvalid), 512'(1'b1));
    d = bus.rdata;
    resp = bus.rresp;
    tick();
    bus.rready = 1'b0;
    $display("read  addr=%h data=%h resp=%0d", a, d, resp);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] rd;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q[i] = (i == 15) ? 32'h0 : RV;

    // Reset state
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_awready", 512'(bus.awready), 512'(1'b1));
    chk("rst_wready",  512'(bus.wready),  512'(1'b1));
    chk("rst_arready", 512'(bus.arready), 512'(1'b1));
    chk("rst_bvalid",  512'(bus.bvalid),  512'(1'b0));
    chk("rst_rvalid",  512'(bus.rvalid),  512'(1'b0));
    chk("rst_pulse",   512'(reg_wr_pulse), 512'(16'h0));
    chk("rst_reg_q",   reg_q, exp_vec());

    // Clear reg2 so the strobe test starts from zero
    do_write(32'h8, 32'h0, 4'hF, resp, pulse);
    exp_q[2] = 32'h0;
    chk("clr2_resp", 512'(resp), 512'(OKAY));
    chk("clr2_reg_q", reg_q, exp_vec());

    // AW five cycles ahead of W, partial strobe
    bus.awaddr = 32'h8; bus.awvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    chk("aw_first_awready", 512'(bus.awready), 512'(1'b0));
    chk("aw_first_wready",  512'(bus.wready),  512'(1'b1));
    tick(); tick(); tick(); tick();
    chk("aw_first_no_b", 512'(bus.bvalid), 512'(1'b0));
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("w_edge_no_b", 512'(bus.bvalid), 512'(1'b0));
    tick();
    exp_q[2] = 32'h00AD_00EF;
    chk("strb_bvalid", 512'(bus.bvalid), 512'(1'b1));
    chk("strb_bresp",  512'(bus.bresp),  512'(OKAY));
    chk("strb_reg_q",  reg_q, exp_vec());
    chk("strb_pulse",  512'(reg_wr_pulse), 512'(16'h0004));
    tick();
    chk("strb_pulse_once", 512'(reg_wr_pulse), 512'(16'h0));
    chk("strb_b_hold", 512'(bus.bvalid), 512'(1'b1));
    bus.bready = 1'b1;
    tick();
    chk("strb_b_drop", 512'(bus.bvalid), 512'(1'b0));
    bus.bready = 1'b0;
    $display("write addr=00000008 data=deadbeef strb=5 split AW/W reg2=%h", reg_q[95:64]);

    // Out-of-range and read-only writes, out-of-range read
    do_write(32'h40, 32'h1111_1111, 4'hF, resp, pulse);
    chk("oor_wr_resp", 512'(resp), 512'(SLVERR));
    chk("oor_wr_pulse", 512'(pulse), 512'(16'h0));
    do_write(32'h3C, 32'h1111_1111, 4'hF, resp, pulse);
    chk("ro_wr_resp", 512'(resp), 512'(SLVERR));
    chk("ro_wr_pulse", 512'(pulse), 512'(16'h0));
    chk("err_reg_q", reg_q, exp_vec());
    do_read(32'h40, rd, resp);
    chk("oor_rd_resp", 512'(resp), 512'(SLVERR));
    chk("oor_rd_data", 512'(rd), 512'(32'h0));
    do_read(32'h3C, rd, resp);
    chk("ro_rd_resp", 512'(resp), 512'(OKAY));
    chk("ro_rd_data", 512'(rd), 512'(HW15));
    do_read(32'h8, rd, resp);
    chk("rd2_data", 512'(rd), 512'(32'h00AD_00EF));

    // Zero strobe: OKAY, pulse, no change
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, resp, pulse);
    chk("strb0_resp", 512'(resp), 512'(OKAY));
    chk("strb0_pulse", 512'(pulse), 512'(16'h0010));
    chk("strb0_reg_q", reg_q, exp_vec());

    // Stalled B with a second write queued behind it
    bus.awaddr = 32'h4; bus.awvalid = 1'b1;
    bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    exp_q[1] = 32'h1111_1111;
    chk("stall_b1_valid", 512'(bus.bvalid), 512'(1'b1));
    chk("stall_b1_pulse", 512'(reg_wr_pulse), 512'(16'h0002));
    bus.awaddr = 32'hC; bus.awvalid = 1'b1;
    bus.wdata = 32'h3333_3333; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("stall_awready", 512'(bus.awready), 512'(1'b0));
    chk("stall_wready",  512'(bus.wready),  512'(1'b0));
    for (int i = 0; i < 8; i++) tick();
    chk("stall_bvalid", 512'(bus.bvalid), 512'(1'b1));
    chk("stall_bresp",  512'(bus.bresp),  512'(OKAY));
    chk("stall_reg_q",  reg_q, exp_vec());
    bus.bready = 1'b1;
    tick();
    exp_q[3] = 32'h3333_3333;
    chk("stall_b2_valid", 512'(bus.bvalid), 512'(1'b1));
    chk("stall_b2_reg_q", reg_q, exp_vec());
    chk("stall_b2_pulse", 512'(reg_wr_pulse), 512'(16'h0008));
    chk("stall_b2_awready", 512'(bus.awready), 512'(1'b1));
    tick();
    chk("stall_b2_drop", 512'(bus.bvalid), 512'(1'b0));
    bus.bready = 1'b0;
    $display("write stalled pair reg1=%h reg3=%h", reg_q[63:32], reg_q[127:96]);

    // W ahead of AW
    bus.wdata = 32'h5555_5555; bus.wstrb = 4'b1000; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("wfirst_wready",  512'(bus.wready),  512'(1'b0));
    chk("wfirst_awready", 512'(bus.awready), 512'(1'b1));
    tick(); tick();
    chk("wfirst_no_b", 512'(bus.bvalid), 512'(1'b0));
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick();
    exp_q[5] = 32'h55A5_0000;
    chk("wfirst_bvalid", 512'(bus.bvalid), 512'(1'b1));
    chk("wfirst_reg_q", reg_q, exp_vec());
    tick();
    bus.bready = 1'b0;
    $display("write W-before-AW reg5=%h", reg_q[191:160]);

    // Read and write commit to reg6 on the same edge
    bus.awaddr = 32'h18; bus.awvalid = 1'b1;
    bus.wdata = 32'h6666_6666; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h18; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    exp_q[6] = 32'h6666_6666;
    chk("raw_rvalid", 512'(bus.rvalid), 512'(1'b1));
    chk("raw_rdata",  512'(bus.rdata),  512'(RV));
    chk("raw_reg_q",  reg_q, exp_vec());
    bus.arvalid = 1'b0; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    $display("read/write same edge reg6 old=%h", RV);

    // Back-to-back reads, one per cycle
    bus.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.araddr = 32'(i * 4); bus.arvalid = 1'b1;
      tick();
      chk("b2b_rvalid", 512'(bus.rvalid), 512'(1'b1));
      chk("b2b_rdata",  512'(bus.rdata),  512'(exp_q[i]));
      chk("b2b_arready", 512'(bus.arready), 512'(1'b1));
      $display("read  b2b addr=%h data=%h", i * 4, bus.rdata);
    end
    bus.arvalid = 1'b0;
    tick();
    chk("b2b_rvalid_end", 512'(bus.rvalid), 512'(1'b0));

    // Stalled R: arready low, data held
    bus.rready = 1'b0; bus.araddr = 32'h8; bus.arvalid = 1'b1;
    tick();
    bus.araddr = 32'h4;
    tick(); tick(); tick();
    chk("rstall_arready", 512'(bus.arready), 512'(1'b0));
    chk("rstall_rvalid",  512'(bus.rvalid),  512'(1'b1));
    chk("rstall_rdata",   512'(bus.rdata),   512'(32'h00AD_00EF));
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    tick();
    chk("rstall_drain", 512'(bus.rvalid), 512'(1'b0));
    bus.rready = 1'b0;
    $display("read  stalled addr=00000008 data=00ad00ef");

    // Reset with AW held and W pending: nothing committed
    bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("rst6_aw_held", 512'(bus.awready), 512'(1'b0));
    bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    reset_n = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    reset_n = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 15; i++) exp_q[i] = RV;
    chk("rst6_bvalid",  512'(bus.bvalid),  512'(1'b0));
    chk("rst6_awready", 512'(bus.awready), 512'(1'b1));
    chk("rst6_reg_q",   reg_q, exp_vec());
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    tick(); tick();
    chk("rst6_w_only_no_b", 512'(bus.bvalid), 512'(1'b0));
    chk("rst6_w_only_reg_q", reg_q, exp_vec());
    $display("reset mid-transaction reg7=%h", reg_q[255:224]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
